mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-outstanding memory port,
// with starvation protection for fetch and a per-transaction ack timeout.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_mask,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic        stall
);

  localparam int SW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam int CW = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [CW-1:0] cnt;

  logic if_elig;
  logic ls_elig;
  logic bubble;
  logic starve;
  logic grant_ls;
  logic grant_if;
  logic timeout_hit;

  assign if_elig     = if_req & ~if_valid;
  assign ls_elig     = ls_req & ~ls_valid;
  // The IDLE cycle that carries a response pulse is the inter-transaction bubble: nobody is granted.
  assign bubble      = if_valid | ls_valid;
  assign starve      = if_elig & (streak == SW'(MAX_WAIT));
  assign grant_ls    = ~bubble & ls_elig & ~starve;
  assign grant_if    = ~bubble & if_elig & ~grant_ls;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  assign stall = (ls_req & ~ls_valid) | (if_req & ~if_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      cnt       <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      ls_rdata  <= '0;
      ls_valid  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_mask  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_mask  <= ls_mask;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            cnt       <= '0;
            state     <= BUSY_LS;
            if (!if_req)
              streak <= '0;
            else if (streak != SW'(MAX_WAIT))
              streak <= streak + 1'b1;
          end else if (grant_if) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_mask <= 4'hF;
            mem_addr <= if_addr;
            cnt      <= '0;
            streak   <= '0;
            state    <= BUSY_IF;
          end
        end
        BUSY_IF, BUSY_LS: begin
          // An ack on the timeout edge still completes the transaction normally.
          if (mem_ack || timeout_hit) begin
            mem_req <= 1'b0;
            bus_err <= ~mem_ack;
            state   <= IDLE;
            if (state == BUSY_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              ls_valid <= 1'b1;
              if (!mem_ack)
                ls_rdata <= '0;
              else if (!mem_we)
                ls_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT issues a grant or a response pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_mask = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] ls_rdata;
  logic        ls_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        bus_err;
  logic        stall;

  mem_port_arbiter #(.MAX_WAIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_mask(ls_mask), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        chk_wdata;
  } gnt_t;

  typedef struct {
    logic        is_if;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  gnt_t  gnt_q[$];
  resp_t resp_q[$];

  int passed = 0;
  int total  = 0;

  // memory model controls
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] rd_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic exp_gnt(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                         input logic [31:0] wdata, input logic chk_wdata);
    gnt_t g;
    g.addr = addr; g.we = we; g.mask = mask; g.wdata = wdata; g.chk_wdata = chk_wdata;
    gnt_q.push_back(g);
  endtask

  task automatic exp_resp(input logic is_if, input logic [31:0] rdata, input logic err);
    resp_t r;
    r.is_if = is_if; r.rdata = rdata; r.err = err;
    resp_q.push_back(r);
  endtask

  // which: 0 = mem_req, 1 = if_valid, 2 = ls_valid, 3 = either valid
  task automatic wait_for(input int which, input int limit, output int cycles);
    logic hit;
    cycles = 0;
    forever begin
      @(posedge clk); #1;
      cycles++;
      hit = (which == 0 && mem_req) || (which == 1 && if_valid) ||
            (which == 2 && ls_valid) || (which == 3 && (if_valid || ls_valid));
      if (hit) break;
      if (cycles >= limit) begin
        total++;
        $display("FAIL wait_event_%0d: none within %0d cycles", which, limit);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory responder: single-cycle ack ack_delay cycles into the mem_req window
  initial begin
    int   bcnt;
    logic acked;
    bcnt = 0; acked = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst || !mem_req) begin
        bcnt = 0; acked = 1'b0;
      end else if (!acked) begin
        if (ack_en && bcnt == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rd_val; acked = 1'b1;
        end
        bcnt++;
      end
    end
  end

  // Monitor: grants and response pulses against the scoreboard queues
  initial begin
    logic  prev_req;
    logic  have_gnt;
    gnt_t  g;
    resp_t r;
    prev_req = 1'b0; have_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0; have_gnt = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          check("grant_expected", gnt_q.size() > 0, 1'b1);
          have_gnt = (gnt_q.size() > 0);
          if (have_gnt) g = gnt_q.pop_front();
        end
        if (mem_req && have_gnt) begin
          check("mem_addr", mem_addr, g.addr);
          check("mem_we", mem_we, g.we);
          check("mem_mask", mem_mask, g.mask);
          if (g.chk_wdata) check("mem_wdata", mem_wdata, g.wdata);
        end
        if (if_valid || ls_valid) begin
          check("resp_expected", resp_q.size() > 0, 1'b1);
          if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            check("valid_owner", {if_valid, ls_valid}, r.is_if ? 2'b10 : 2'b01);
            check("resp_rdata", r.is_if ? if_rdata : ls_rdata, r.rdata);
            check("bus_err", bus_err, r.err);
          end
        end
        prev_req = mem_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pulses;

    // reset state
    idle(3);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_mask", mem_mask, 4'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_ls_valid", ls_valid, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_stall", stall, 1'b0);
    rst = 1'b1;
    idle(2);

    // single fetch, ack on first mem_req cycle
    rd_val = 32'h0050_0093; ack_delay = 0;
    exp_gnt(32'h100, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_resp(1'b1, 32'h0050_0093, 1'b0);
    if_addr = 32'h100; if_req = 1'b1;
    #1 check("stall_fetch_pending", stall, 1'b1);
    wait_for(1, 10, cyc);
    check("fetch_latency", cyc, 2);
    if_req = 1'b0;
    idle(2);

    // load, ack one cycle late
    rd_val = 32'h1234_5678; ack_delay = 1;
    exp_gnt(32'h1000, 1'b0, 4'hF, 32'h0, 1'b1);
    exp_resp(1'b0, 32'h1234_5678, 1'b0);
    ls_addr = 32'h1000; ls_we = 1'b0; ls_mask = 4'hF; ls_wdata = 32'h0; ls_req = 1'b1;
    wait_for(2, 10, cyc);
    check("load_latency", cyc, 3);
    ls_req = 1'b0;
    idle(2);

    // store, ack after 3 cycles; load data register must keep the previous load
    rd_val = 32'hFFFF_FFFF; ack_delay = 3;
    exp_gnt(32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b1);
    exp_resp(1'b0, 32'h1234_5678, 1'b0);
    ls_addr = 32'h2000; ls_we = 1'b1; ls_mask = 4'b0011; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
    wait_for(2, 12, cyc);
    check("store_latency", cyc, 5);
    ls_req = 1'b0; ls_we = 1'b0;
    idle(2);

    // fetch request held through its valid cycle
    rd_val = 32'h1111_1111; ack_delay = 0;
    exp_gnt(32'h104, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_resp(1'b1, 32'h1111_1111, 1'b0);
    exp_gnt(32'h104, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_resp(1'b1, 32'h2222_2222, 1'b0);
    if_addr = 32'h104; if_req = 1'b1;
    wait_for(1, 10, cyc);
    check("stall_during_valid", stall, 1'b0);
    rd_val = 32'h2222_2222;
    idle(1);
    check("no_regrant_on_valid_edge", mem_req, 1'b0);
    idle(1);
    check("regrant_next_edge", mem_req, 1'b1);
    if_req = 1'b0;
    wait_for(1, 10, cyc);
    idle(2);

    // contention: LS x4, IF, LS
    rd_val = 32'hCAFE_F00D; ack_delay = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        exp_gnt(32'h200, 1'b0, 4'hF, 32'h0, 1'b0);
        exp_resp(1'b1, 32'hCAFE_F00D, 1'b0);
      end else begin
        exp_gnt(32'h4000, 1'b0, 4'hF, 32'h55AA_55AA, 1'b1);
        exp_resp(1'b0, 32'hCAFE_F00D, 1'b0);
      end
    end
    if_addr = 32'h200;
    ls_addr = 32'h4000; ls_we = 1'b0; ls_mask = 4'hF; ls_wdata = 32'h55AA_55AA;
    if_req = 1'b1; ls_req = 1'b1;
    for (int i = 0; i < 6; i++) wait_for(3, 10, cyc);
    if_req = 1'b0; ls_req = 1'b0;
    idle(2);

    // timeout on a load with no ack
    ack_en = 1'b0;
    exp_gnt(32'h3000, 1'b0, 4'hF, 32'h0, 1'b1);
    exp_resp(1'b0, 32'h0, 1'b1);
    ls_addr = 32'h3000; ls_wdata = 32'h0; ls_req = 1'b1;
    wait_for(0, 5, cyc);
    ls_req = 1'b0;
    wait_for(2, 40, cyc);
    check("timeout_cycles", cyc, 16);
    check("timeout_ls_rdata", ls_rdata, 32'h0);
    ack_en = 1'b1;
    idle(2);

    // normal transaction after the abort
    rd_val = 32'hABCD_0001;
    exp_gnt(32'h300, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_resp(1'b1, 32'hABCD_0001, 1'b0);
    if_addr = 32'h300; if_req = 1'b1;
    wait_for(1, 10, cyc);
    check("post_timeout_latency", cyc, 2);
    if_req = 1'b0;
    idle(2);

    // reset in the second BUSY_LS cycle
    ack_en = 1'b0;
    exp_gnt(32'h5000, 1'b0, 4'hF, 32'h0, 1'b1);
    ls_addr = 32'h5000; ls_req = 1'b1;
    wait_for(0, 5, cyc);
    ls_req = 1'b0;
    idle(1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 1'b0);
    check("async_rst_mem_mask", mem_mask, 4'h0);
    check("async_rst_mem_addr", mem_addr, 32'h0);
    check("async_rst_if_rdata", if_rdata, 32'h0);
    check("async_rst_ls_rdata", ls_rdata, 32'h0);
    idle(1);
    rst = 1'b1; ack_en = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (if_valid || ls_valid || mem_req) pulses++;
    end
    check("no_replay_after_reset", pulses, 0);

    rd_val = 32'h0BAD_F00D;
    exp_gnt(32'h400, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_resp(1'b1, 32'h0BAD_F00D, 1'b0);
    if_addr = 32'h400; if_req = 1'b1;
    wait_for(1, 10, cyc);
    check("post_reset_latency", cyc, 2);
    if_req = 1'b0;
    idle(3);

    check("grants_drained", gnt_q.size(), 0);
    check("responses_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
